// File: rtl/frequency_divider_by2_pkg.sv
// -----------------------------------------------------------------------------
// frequency_divider_by2_pkg
// Shared constants and helpers for the even-ratio clock divider.
//   DIVIDE_DEFAULT : default division ratio
//   DIVIDE_MIN/MAX : legal range of the division ratio (must also be even)
//   min_cnt_w()    : smallest half-period counter width able to reach DIVIDE/2
// -----------------------------------------------------------------------------
package frequency_divider_by2_pkg;

  localparam int DIVIDE_DEFAULT = 2;
  localparam int DIVIDE_MIN     = 2;
  localparam int DIVIDE_MAX     = 65536;

  // Smallest width w (at least 1) with 2**w >= divide/2.
  function automatic int min_cnt_w(input int divide);
    int w;
    w = 1;
    while ((64'd1 << w) < 64'(divide / 2)) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/frequency_divider_by2.sv
// -----------------------------------------------------------------------------
// frequency_divider_by2
// Divides clk by an even ratio DIVIDE, producing a 50% duty-cycle out_clk.
// A half-period counter runs 0..DIVIDE/2-1; on its last value out_clk toggles
// and the counter wraps on the same edge. For DIVIDE=2 the counter stays at 0
// and out_clk toggles every edge.
//
// Parameters:
//   DIVIDE : even division ratio, 2..65536
//   CNT_W  : half-period counter width, 2**CNT_W >= DIVIDE/2
// Ports:
//   clk     in  1  single clock, all state updates on its rising edge
//   rst     in  1  synchronous active-low reset
//   out_clk out 1  divided clock, straight from a flip-flop
// -----------------------------------------------------------------------------
module frequency_divider_by2
  import frequency_divider_by2_pkg::*;
#(
  parameter int DIVIDE = DIVIDE_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic clk,
  input  logic rst,
  output logic out_clk
);

  // Reject illegal configurations at elaboration time.
  if (DIVIDE < DIVIDE_MIN || DIVIDE > DIVIDE_MAX || (DIVIDE % 2) != 0) begin : g_bad_divide
    $fatal(1, "frequency_divider_by2: DIVIDE=%0d must be even and within %0d..%0d",
           DIVIDE, DIVIDE_MIN, DIVIDE_MAX);
  end

  if (CNT_W < min_cnt_w(DIVIDE)) begin : g_bad_cnt_w
    $fatal(1, "frequency_divider_by2: CNT_W=%0d too narrow for DIVIDE=%0d (need %0d)",
           CNT_W, DIVIDE, min_cnt_w(DIVIDE));
  end

  // Terminal count of the half-period counter. For DIVIDE=2 this is 0, so the
  // counter never leaves 0 and out_clk toggles on every edge.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDE / 2 - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: reset is tested inside the clocked block (not in the sensitivity
  // list), so rst activity between edges cannot disturb out_clk; sequential
  // state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      out_clk <= 1'b0;
    end else if (cnt == LAST) begin
      cnt     <= '0;
      out_clk <= ~out_clk;
    end else begin
      cnt     <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_frequency_divider_by2.sv
// -----------------------------------------------------------------------------
// tb_frequency_divider_by2
// Drives a DIVIDE=2 and a DIVIDE=6 instance from one 20 ns clock (first rising
// edge at 10 ns). Stimulus is applied on falling edges; the expected outputs
// for each edge are pushed to a scoreboard queue and popped 1 ns after the
// following rising edge for comparison.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_frequency_divider_by2;

  typedef struct {
    logic rst2;
    logic rst6;
    logic e2;
    logic e6;
    int   ecnt6;
  } vec_t;

  typedef struct {
    string tag;
    logic  e2;
    logic  e6;
    int    ecnt6;
  } exp_t;

  logic clk;
  logic rst2;
  logic rst6;
  logic out2;
  logic out6;

  int tests;
  int failed;

  exp_t sb[$];

  frequency_divider_by2 #(.DIVIDE(2), .CNT_W(16)) dut2 (
    .clk     (clk),
    .rst     (rst2),
    .out_clk (out2)
  );

  frequency_divider_by2 #(.DIVIDE(6), .CNT_W(16)) dut6 (
    .clk     (clk),
    .rst     (rst6),
    .out_clk (out6)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Any change of either output must land on a rising clock edge (t = 10 mod 20).
  always @(out2 or out6) begin
    if ($time != 0) begin
      check("edge_align", 32'($time % 20), 32'd10);
    end
  end

  // Drive one edge's stimulus, queue its expectation, then compare after the edge.
  task automatic step(input string tag, input logic r2, input logic r6,
                      input logic e2, input logic e6, input int ecnt6);
    exp_t e;
    rst2 = r2;
    rst6 = r6;
    e.tag = tag; e.e2 = e2; e.e6 = e6; e.ecnt6 = ecnt6;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_out2"}, 32'(out2), 32'(e.e2));
      check({e.tag, "_out6"}, 32'(out6), 32'(e.e6));
      check({e.tag, "_cnt6"}, 32'(dut6.cnt), 32'(e.ecnt6));
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[15];
  logic hold2;
  logic hold6;

  initial begin
    tests  = 0;
    failed = 0;

    // Edge n is the n-th rising edge (10 ns, 30 ns, ...). Edges 1..11 cover
    // start-up timing; 12..15 pulse reset mid-phase on each instance.
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0}; // reset edge at 10 ns
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 0}; // /6 rises after 3rd edge
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0}; // /6 falls after 6th edge
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 0}; // /6 rises after 9th edge
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1}; // /6 high, counter=1
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 0}; // /6 reset mid-high
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1}; // /2 reset while high
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 2}; // /2 resumes with 1
    vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 0}; // /6 rises 3 edges after release

    for (int i = 0; i < 15; i++) begin
      step($sformatf("vec%0d", i), vecs[i].rst2, vecs[i].rst6,
           vecs[i].e2, vecs[i].e6, vecs[i].ecnt6);
    end

    // Reset held low for 10 edges keeps both outputs at 0.
    for (int i = 0; i < 10; i++) begin
      step("hold_rst", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    end

    // Sustained run over 100 periods of the /6 output. After the k-th edge
    // with reset released: /2 output = k mod 2, /6 output = (k/3) mod 2.
    // During the first few edges reset glitches low between edges, which
    // must not change either output.
    for (int k = 1; k <= 600; k++) begin
      step("run", 1'b1, 1'b1, 1'(k % 2), 1'((k / 3) % 2), k % 3);
      if (k <= 8) begin
        hold2 = out2;
        hold6 = out6;
        #2;
        rst2 = 1'b0;
        rst6 = 1'b0;
        #3;
        rst2 = 1'b1;
        rst6 = 1'b1;
        #1;
        check("glitch_out2", 32'(out2), 32'(hold2));
        check("glitch_out6", 32'(out6), 32'(hold6));
      end
    end

    // Final assert: reset both and confirm they return to 0.
    step("final_rst", 1'b0, 1'b0, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
